pll_seq_ctl: RTL and testbench
==============================

Name: pll_seq_ctl

Overview:
Controller on the initiator side of the on-chip PLL macro. It drives the macro's standby and divider inputs and watches its lock indicator. It sequences divider programming, standby release, lock wait with timeout, and lock settle, then raises a clock-enable for downstream logic. It runs in the reference-clock domain, so divider changes only ever happen while the PLL is in standby.

Parameters:
SETUP_CYC, 16, cycles dividers are held stable with standby asserted before release (minimum 16)
LOCK_TIMEOUT, 1024, cycles allowed in WAKE for synchronized lock before failure
SETTLE_CYC, 8, consecutive synchronized-lock cycles required before RUN
CNT_W, 12, width of the shared sequencing counter; must hold max(SETUP_CYC, LOCK_TIMEOUT, SETTLE_CYC)

Ports:
clk  in  1  reference clock, same clock as PLL RCLK
reset_l  in  1  synchronous active-low reset
start  in  1  one-cycle pulse; begins a lock sequence from IDLE, FAIL or LOST
stop  in  1  one-cycle pulse; forces the PLL to standby from any state
cfg_wr  in  1  load the cfg_* shadow registers
cfg_m  in  1  M divider value
cfg_n  in  4  N divider value
cfg_pa  in  4  port A divider value
cfg_pb  in  4  port B divider value
cfg_pc  in  4  port C divider value
pb_en  in  1  port B enable
pc_en  in  1  port C enable
pll_lock  in  1  PLL lock indicator (asynchronous)
pll_stby  out  1  PLL standby
pll_m0  out  1  M divider to PLL
pll_n  out  4  N divider to PLL
pll_pa  out  4  port A divider to PLL
pll_pb  out  4  port B divider to PLL
pll_pc  out  4  port C divider to PLL
pll_pbstby  out  1  port B standby
pll_pcstby  out  1  port C standby
clk_en  out  1  downstream clock enable
locked  out  1  status: in RUN
busy  out  1  status: in PROG, WAKE or SETTLE
err_timeout  out  1  sticky; lock was not seen within LOCK_TIMEOUT
err_lost  out  1  sticky; lock dropped while in RUN
cfg_err  out  1  one-cycle pulse; cfg_wr rejected

Behaviour:
- Reset (reset_l=0 at a clk edge), all outputs registered:
  - pll_stby=1; all divider outputs 0; pll_pbstby=1, pll_pcstby=1.
  - clk_en, locked, busy, err_timeout, err_lost, cfg_err all 0.
  - State is IDLE; sync flops and counter are 0.
- Lock synchronizer: pll_lock passes through a 2-flop synchronizer to give lock_s, a fixed 2-cycle latency. All decisions use lock_s.
- Divider configuration:
  - The pll_* divider outputs are the shadow registers.
  - cfg_wr is accepted only in IDLE, FAIL or LOST. The shadows update on the next edge.
  - cfg_wr in any other state is ignored, and cfg_err pulses one cycle later.
- Port standby:
  - pll_pbstby = ~pb_en | pll_stby and pll_pcstby = ~pc_en | pll_stby, both registered.
  - These may change in any state.
- State machine (counter cleared on every state entry):
  - IDLE: pll_stby=1. On start: go to PROG; err_timeout and err_lost clear.
  - PROG: pll_stby=1, busy=1. Counter increments; at SETUP_CYC-1 go to WAKE.
  - WAKE: pll_stby=0, busy=1.
    - lock_s=1 → SETTLE.
    - Counter reaches LOCK_TIMEOUT-1 with lock_s=0 → FAIL.
  - SETTLE: busy=1.
    - Counter counts consecutive lock_s=1 cycles; reaching SETTLE_CYC-1 → RUN.
    - lock_s=0 → back to WAKE with a fresh timeout.
  - RUN: locked=1, clk_en=1. lock_s=0 → LOST; clk_en drops at the same edge; err_lost=1.
  - FAIL: pll_stby=1, err_timeout=1. Waits for start, which goes to PROG.
  - LOST: pll_stby=1. Waits for start, which goes to PROG (see Optional Feature).
- stop in any state → IDLE at the next edge: pll_stby=1, clk_en=0. Error flags keep their values.
- start and stop in the same cycle: stop wins. start in PROG, WAKE, SETTLE or RUN is ignored.
- Latency, start to clk_en with pll_lock already high at WAKE entry: SETUP_CYC + 2 + SETTLE_CYC cycles ±1, where the fixed 2 is the sync latency. Benches check the exact edge.
- Counter saturates and never wraps.

Optional Feature:
PLL_SEQ_CTL_AUTO_RELOCK_EN
- Defined: lock loss in RUN still sets err_lost, then goes directly to PROG (not LOST) and relocks with the current shadows. No start is needed.
- Undefined: the block stays in LOST until start.

Test Plan:
1. Reset; cfg_wr M=1, N=3, PA=1; start; pll_lock rises 40 cycles after pll_stby falls → pll_stby falls 16 cycles after PROG entry; clk_en=1 exactly SETTLE_CYC+2 cycles after pll_lock rises; outputs M0=1, N=3, PA=1.
2. start, pll_lock held 0 → after 1024 cycles in WAKE: state FAIL, pll_stby=1, err_timeout=1; then start clears err_timeout.
3. In SETTLE, drop pll_lock for 1 cycle at settle count 5 → return to WAKE; clk_en stays 0 until 8 fresh consecutive lock cycles.
4. In RUN, drop pll_lock → clk_en=0 two cycles later, err_lost=1. Without the macro: state LOST, pll_stby=1. With the macro: PROG, then relock.
5. cfg_wr during WAKE → cfg_err pulse; pll_n unchanged. stop+start in the same cycle during RUN → IDLE, pll_stby=1.
6. pb_en=0 in RUN → pll_pbstby=1 next cycle; locked stays 1.

Source files
------------

// File: rtl/pll_seq_ctl.sv
// Reference-clock-domain sequencer for the on-chip PLL: program dividers in standby,
// release, wait for lock, settle, then enable the downstream clock. Optional: PLL_SEQ_CTL_AUTO_RELOCK_EN.
module pll_seq_ctl #(
  parameter int SETUP_CYC    = 16,
  parameter int LOCK_TIMEOUT = 1024,
  parameter int SETTLE_CYC   = 8,
  parameter int CNT_W        = 12
) (
  input  logic       clk,
  input  logic       reset_l,
  input  logic       start,
  input  logic       stop,
  input  logic       cfg_wr,
  input  logic       cfg_m,
  input  logic [3:0] cfg_n,
  input  logic [3:0] cfg_pa,
  input  logic [3:0] cfg_pb,
  input  logic [3:0] cfg_pc,
  input  logic       pb_en,
  input  logic       pc_en,
  input  logic       pll_lock,
  output logic       pll_stby,
  output logic       pll_m0,
  output logic [3:0] pll_n,
  output logic [3:0] pll_pa,
  output logic [3:0] pll_pb,
  output logic [3:0] pll_pc,
  output logic       pll_pbstby,
  output logic       pll_pcstby,
  output logic       clk_en,
  output logic       locked,
  output logic       busy,
  output logic       err_timeout,
  output logic       err_lost,
  output logic       cfg_err
);

  typedef enum logic [2:0] {
    IDLE, PROG, WAKE, SETTLE, RUN, FAIL, LOST
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             lock_q1, lock_s;
  logic             cfg_ok, start_ok, stby_d;

  // Divider changes and restarts are only legal while the PLL sits in standby.
  assign cfg_ok   = (state_q == IDLE) || (state_q == FAIL) || (state_q == LOST);
  assign start_ok = start && !stop && cfg_ok;
  assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  assign stby_d   = (state_d == IDLE) || (state_d == PROG) ||
                    (state_d == FAIL) || (state_d == LOST);

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, FAIL, LOST: if (start) state_d = PROG;
      PROG: begin
        if (cnt_q == CNT_W'(SETUP_CYC - 1)) state_d = WAKE;
        else                                cnt_d   = cnt_inc;
      end
      WAKE: begin
        if (lock_s)                                   state_d = SETTLE;
        else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1))   state_d = FAIL;
        else                                          cnt_d   = cnt_inc;
      end
      SETTLE: begin
        if (!lock_s)                              state_d = WAKE;
        else if (cnt_q == CNT_W'(SETTLE_CYC - 1)) state_d = RUN;
        else                                      cnt_d   = cnt_inc;
      end
      RUN: begin
`ifdef PLL_SEQ_CTL_AUTO_RELOCK_EN
        if (!lock_s) state_d = PROG;
`else
        if (!lock_s) state_d = LOST;
`endif
      end
      default: state_d = IDLE;
    endcase
    if (stop) state_d = IDLE;
    if (state_d != state_q) cnt_d = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      lock_q1     <= 1'b0;
      lock_s      <= 1'b0;
      pll_stby    <= 1'b1;
      pll_m0      <= 1'b0;
      pll_n       <= '0;
      pll_pa      <= '0;
      pll_pb      <= '0;
      pll_pc      <= '0;
      pll_pbstby  <= 1'b1;
      pll_pcstby  <= 1'b1;
      clk_en      <= 1'b0;
      locked      <= 1'b0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
      err_lost    <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      lock_q1 <= pll_lock;
      lock_s  <= lock_q1;
      state_q <= state_d;
      cnt_q   <= cnt_d;

      if (cfg_wr && cfg_ok) begin
        pll_m0 <= cfg_m;
        pll_n  <= cfg_n;
        pll_pa <= cfg_pa;
        pll_pb <= cfg_pb;
        pll_pc <= cfg_pc;
      end
      cfg_err <= cfg_wr && !cfg_ok;

      // Outputs decode the next state so they change on the same edge as the state.
      pll_stby   <= stby_d;
      pll_pbstby <= ~pb_en | stby_d;
      pll_pcstby <= ~pc_en | stby_d;
      clk_en     <= (state_d == RUN);
      locked     <= (state_d == RUN);
      busy       <= (state_d == PROG) || (state_d == WAKE) || (state_d == SETTLE);

      if (start_ok)                                      err_timeout <= 1'b0;
      else if (state_q == WAKE && state_d == FAIL)       err_timeout <= 1'b1;
      if (start_ok)                                      err_lost    <= 1'b0;
      else if (state_q == RUN && !lock_s && !stop)       err_lost    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pll_seq_ctl.sv
// Scoreboard bench for pll_seq_ctl: stimulus schedules expected output values at
// absolute cycle numbers; a negedge monitor pops and compares them.
module tb_pll_seq_ctl;

  typedef enum int {
    S_STBY, S_CLKEN, S_LOCKED, S_BUSY, S_ETO, S_ELOST, S_CFGERR,
    S_M0, S_N, S_PA, S_PB, S_PC, S_PBSTBY, S_PCSTBY
  } sel_t;

  typedef struct {
    int         cyc;
    sel_t       sel;
    logic [7:0] val;
    string      name;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_l, start, stop, cfg_wr, cfg_m, pb_en, pc_en, pll_lock;
  logic [3:0] cfg_n, cfg_pa, cfg_pb, cfg_pc;
  logic       pll_stby, pll_m0, pll_pbstby, pll_pcstby;
  logic [3:0] pll_n, pll_pa, pll_pb, pll_pc;
  logic       clk_en, locked, busy, err_timeout, err_lost, cfg_err;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  pll_seq_ctl dut (
    .clk(clk), .reset_l(reset_l), .start(start), .stop(stop),
    .cfg_wr(cfg_wr), .cfg_m(cfg_m), .cfg_n(cfg_n), .cfg_pa(cfg_pa),
    .cfg_pb(cfg_pb), .cfg_pc(cfg_pc), .pb_en(pb_en), .pc_en(pc_en),
    .pll_lock(pll_lock), .pll_stby(pll_stby), .pll_m0(pll_m0),
    .pll_n(pll_n), .pll_pa(pll_pa), .pll_pb(pll_pb), .pll_pc(pll_pc),
    .pll_pbstby(pll_pbstby), .pll_pcstby(pll_pcstby), .clk_en(clk_en),
    .locked(locked), .busy(busy), .err_timeout(err_timeout),
    .err_lost(err_lost), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] probe(sel_t s);
    case (s)
      S_STBY:   return {7'd0, pll_stby};
      S_CLKEN:  return {7'd0, clk_en};
      S_LOCKED: return {7'd0, locked};
      S_BUSY:   return {7'd0, busy};
      S_ETO:    return {7'd0, err_timeout};
      S_ELOST:  return {7'd0, err_lost};
      S_CFGERR: return {7'd0, cfg_err};
      S_M0:     return {7'd0, pll_m0};
      S_N:      return {4'd0, pll_n};
      S_PA:     return {4'd0, pll_pa};
      S_PB:     return {4'd0, pll_pb};
      S_PC:     return {4'd0, pll_pc};
      S_PBSTBY: return {7'd0, pll_pbstby};
      S_PCSTBY: return {7'd0, pll_pcstby};
      default:  return 8'hxx;
    endcase
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic expect_at(input string name, input sel_t s, input logic [7:0] v, input int at);
    exp_t e;
    e.cyc = at; e.sel = s; e.val = v; e.name = name;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) tick(1);
  endtask

  // Monitor: compare every scheduled expectation when its cycle is presented.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        check(sb[i].name, probe(sb[i].sel), sb[i].val);
        sb.delete(i);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, p, x, d, f0, g0, s;
    reset_l = 1'b0; start = 1'b0; stop = 1'b0; cfg_wr = 1'b0; cfg_m = 1'b0;
    cfg_n = '0; cfg_pa = '0; cfg_pb = '0; cfg_pc = '0;
    pb_en = 1'b1; pc_en = 1'b1; pll_lock = 1'b0;

    // Reset state
    tick(3);
    expect_at("rst_stby",   S_STBY,   1, cyc);
    expect_at("rst_clken",  S_CLKEN,  0, cyc);
    expect_at("rst_locked", S_LOCKED, 0, cyc);
    expect_at("rst_busy",   S_BUSY,   0, cyc);
    expect_at("rst_eto",    S_ETO,    0, cyc);
    expect_at("rst_elost",  S_ELOST,  0, cyc);
    expect_at("rst_cfgerr", S_CFGERR, 0, cyc);
    expect_at("rst_n",      S_N,      0, cyc);
    expect_at("rst_pa",     S_PA,     0, cyc);
    expect_at("rst_pbstby", S_PBSTBY, 1, cyc);
    reset_l = 1'b1;
    tick(2);

    // Configure in IDLE, start, lock rises 40 cycles after standby release
    cfg_wr = 1'b1; cfg_m = 1'b1; cfg_n = 4'd3; cfg_pa = 4'd1; cfg_pb = 4'd2; cfg_pc = 4'd5;
    tick(1);
    cfg_wr = 1'b0;
    expect_at("cfg_n_idle", S_N, 3, cyc);
    start = 1'b1;
    e0 = cyc + 1;
    tick(1);
    start = 1'b0;
    expect_at("prog_busy",     S_BUSY,   1, e0);
    expect_at("prog_stby_hi",  S_STBY,   1, e0 + 15);
    expect_at("wake_stby_lo",  S_STBY,   0, e0 + 16);
    expect_at("wake_pbstby",   S_PBSTBY, 0, e0 + 20);
    p = e0 + 56;                      // first edge that samples pll_lock high
    wait_cyc(p - 1);
    pll_lock = 1'b1;
    expect_at("t1_clken_pre", S_CLKEN,  0, p + 9);
    expect_at("t1_busy_pre",  S_BUSY,   1, p + 9);
    expect_at("t1_clken",     S_CLKEN,  1, p + 10);
    expect_at("t1_locked",    S_LOCKED, 1, p + 10);
    expect_at("t1_busy",      S_BUSY,   0, p + 10);
    expect_at("t1_m0",        S_M0,     1, p + 10);
    expect_at("t1_n",         S_N,      3, p + 10);
    expect_at("t1_pa",        S_PA,     1, p + 10);
    expect_at("t1_pb",        S_PB,     2, p + 10);
    expect_at("t1_pc",        S_PC,     5, p + 10);
    expect_at("t1_pcstby",    S_PCSTBY, 0, p + 10);
    wait_cyc(p + 12);

    // Port B disable while running
    x = cyc;
    pb_en = 1'b0;
    expect_at("t6_pbstby_pre", S_PBSTBY, 0, x);
    expect_at("t6_pbstby",     S_PBSTBY, 1, x + 1);
    expect_at("t6_locked",     S_LOCKED, 1, x + 1);
    tick(2);
    pb_en = 1'b1;

    // Lock loss in RUN
    d = cyc + 1;
    pll_lock = 1'b0;
    expect_at("t4_clken_pre", S_CLKEN,  1, d + 1);
    expect_at("t4_elost_pre", S_ELOST,  0, d + 1);
    expect_at("t4_clken",     S_CLKEN,  0, d + 2);
    expect_at("t4_elost",     S_ELOST,  1, d + 2);
    expect_at("t4_stby",      S_STBY,   1, d + 2);
    expect_at("t4_locked",    S_LOCKED, 0, d + 2);
`ifdef PLL_SEQ_CTL_AUTO_RELOCK_EN
    expect_at("t4_busy_prog", S_BUSY,   1, d + 2);
`else
    expect_at("t4_busy_lost", S_BUSY,   0, d + 2);
`endif
    wait_cyc(d + 2);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    expect_at("stop_elost_kept", S_ELOST, 1, cyc);
    expect_at("stop_busy",       S_BUSY,  0, cyc);
    expect_at("stop_stby",       S_STBY,  1, cyc);
    tick(2);

    // Timeout with lock held low; rejected cfg_wr during WAKE
    start = 1'b1;
    f0 = cyc + 1;
    tick(1);
    start = 1'b0;
    expect_at("t2_elost_clr", S_ELOST, 0, f0);
    expect_at("t2_busy",      S_BUSY,  1, f0);
    wait_cyc(f0 + 20);
    cfg_wr = 1'b1; cfg_n = 4'd7;
    expect_at("t5_cfgerr_pre",  S_CFGERR, 0, f0 + 20);
    expect_at("t5_cfgerr",      S_CFGERR, 1, f0 + 21);
    expect_at("t5_cfgerr_post", S_CFGERR, 0, f0 + 22);
    expect_at("t5_n_kept",      S_N,      3, f0 + 22);
    expect_at("t5_stby",        S_STBY,   0, f0 + 22);
    expect_at("t2_eto_pre",     S_ETO,    0, f0 + 1039);
    expect_at("t2_stby_pre",    S_STBY,   0, f0 + 1039);
    expect_at("t2_eto",         S_ETO,    1, f0 + 1040);
    expect_at("t2_stby",        S_STBY,   1, f0 + 1040);
    expect_at("t2_busy_fail",   S_BUSY,   0, f0 + 1040);
    tick(1);
    cfg_wr = 1'b0;
    wait_cyc(f0 + 1042);
    start = 1'b1;
    g0 = cyc + 1;
    tick(1);
    start = 1'b0;
    expect_at("t2_eto_clr", S_ETO,  0, g0);
    expect_at("t2_restart", S_BUSY, 1, g0);

    // One-cycle lock dropout at settle count 5
    p = g0 + 20;
    wait_cyc(p - 1);
    pll_lock = 1'b1;
    expect_at("t3_rewake_busy", S_BUSY,  1, p + 8);
    expect_at("t3_rewake_stby", S_STBY,  0, p + 8);
    expect_at("t3_clken_orig",  S_CLKEN, 0, p + 10);
    expect_at("t3_clken_pre",   S_CLKEN, 0, p + 16);
    expect_at("t3_clken",       S_CLKEN, 1, p + 17);
    wait_cyc(p + 5);
    pll_lock = 1'b0;
    tick(1);
    pll_lock = 1'b1;

    // stop and start together while running
    wait_cyc(p + 20);
    stop = 1'b1; start = 1'b1;
    s = cyc + 1;
    expect_at("t5b_clken_pre", S_CLKEN,  1, p + 20);
    expect_at("t5b_clken",     S_CLKEN,  0, s);
    expect_at("t5b_stby",      S_STBY,   1, s);
    expect_at("t5b_locked",    S_LOCKED, 0, s);
    expect_at("t5b_busy",      S_BUSY,   0, s);
    expect_at("t5b_busy_idle", S_BUSY,   0, s + 1);
    expect_at("t5b_stby_idle", S_STBY,   1, s + 1);
    expect_at("t5b_eto",       S_ETO,    0, s + 1);
    expect_at("t5b_pcstby",    S_PCSTBY, 1, s + 2);
    tick(1);
    stop = 1'b0; start = 1'b0;
    tick(5);

    foreach (sb[i]) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: expectation for cycle %0d never evaluated", sb[i].name, sb[i].cyc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
